ternary_mvm_stream: RTL and testbench
=====================================

# ternary_mvm_stream

Streaming ternary matrix-vector multiplier, the parametrised successor of the fixed 16x8 ternary multiply tile. Consumes an input vector of `IN_LEN` signed elements, `LANES` elements per beat, with the matching ternary weight slice on each beat. It accumulates `OUT_LEN` dot products and drains them serially through a valid/ready output port. A double-buffered output bank lets the next vector accumulate while the previous result drains; output rounding mode (wrap or saturate) is selectable.

## Interface
Parameters:
- `IN_LEN`, 16, input vector length; must be a multiple of `LANES`
- `OUT_LEN`, 8, number of outputs (matrix columns)
- `BIT_WIDTH`, 8, signed width of input elements and output words
- `LANES`, 2, input elements consumed per accepted beat (>=1)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous reset, active-high
- `clear`  in  1  abort partial vector accumulation (sync)
- `sat_en`  in  1  1 = saturate output, 0 = wrap (truncate)
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  input beat accepted when both high
- `in_data`  in  `LANES*BIT_WIDTH`  signed elements; lane k at `[k*BIT_WIDTH +: BIT_WIDTH]`
- `in_w`  in  `2*LANES*OUT_LEN`  ternary weights; lane k, output j at `[2*(k*OUT_LEN+j) +: 2]`
- `out_valid`  out  1  output word valid
- `out_ready`  in  1  output word consumed when both high
- `out_data`  out  `BIT_WIDTH`  signed result for `out_idx`
- `out_idx`  out  `$clog2(OUT_LEN)`  output index, 0 first
- `out_last`  out  1  high with `out_idx == OUT_LEN-1`

## Operation
- Weight code: `2'b00` = 0, `2'b01` = +1, `2'b1x` = -1 (bit 1 has priority).
- `BEATS = IN_LEN/LANES`. Beat counter `beat_cnt` runs 0..BEATS-1 and increments on each input handshake.
- Accumulators are `ACC_W = BIT_WIDTH + $clog2(IN_LEN) + 1` bits, signed, one per output.
  - Beat 0 overwrites: `acc[j] = term[j]`.
  - Later beats add: `acc[j] += term[j]`.
  - `term[j]` is the sum over lanes of ±`in_data[k]` or 0.
- Accumulate FSM, states ACCUM and FULL:
  - ACCUM: `in_ready=1`. A handshake on beat BEATS-1 moves to FULL and resets `beat_cnt` to 0.
  - FULL: `in_ready=0`. When the output bank is empty, transfer all accumulators to the bank and return to ACCUM.
  - Transfer applies `sat_en` as sampled in the transfer cycle:
    - saturate clamps to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1];
    - wrap keeps the low `BIT_WIDTH` bits.
- Output bank, states EMPTY and DRAIN:
  - DRAIN: `out_valid=1`, `out_data=bank[out_idx]`.
  - Each output handshake increments `out_idx`.
  - A handshake with `out_last` returns to EMPTY and resets `out_idx` to 0.
- `clear`: sets `beat_cnt` to 0 and forces ACCUM. It does not touch the output bank. A beat presented in the same cycle is discarded; `in_ready` may still read 1. If `clear` and a transfer coincide, `clear` wins and no transfer occurs.
- `rst` (overrides everything, including mid-drain):
  - `beat_cnt=0`, accumulators=0, state ACCUM, bank EMPTY, `out_idx=0`;
  - `out_valid=0`, `out_last=0`, `out_data=0`;
  - `in_ready=0` while `rst` is high, 1 in the first cycle after release.

## Timing
- The final beat is accepted at edge N and the FSM is in FULL during cycle N+1.
- If the bank is empty, transfer happens at edge N+1. From cycle N+2: `out_valid=1`, `out_idx=0`, `in_ready=1`.
- If the bank is draining, transfer happens at the edge after the `out_last` handshake. There is no bubble beyond that one cycle in EMPTY.
- Drain rate is one word per cycle under continuous `out_ready`. A full vector therefore takes BEATS + 1 + OUT_LEN cycles without stalls.
- While `out_valid=1 && out_ready=0`, `out_data`, `out_idx` and `out_last` hold stable.
- All outputs are registered or decoded from registered state. No combinational path from `in_*` to `out_*`.

## Structure
- Package `ternary_pkg`: weight code constants (`W_ZERO`, `W_POS`, `W_NEG_BIT`), accumulate and bank state enums, and function `sat_trunc(acc, sat_en)`.
- Sub-module `ternary_lane_term`: combinational, one instance per output. Takes `LANES` elements and `LANES` 2-bit weights and produces the signed `term`, `ACC_W` bits wide.
- Top holds the counters, FSMs, accumulators and output bank.

## Test plan
Defaults: `IN_LEN=16`, `LANES=2`, `OUT_LEN=8`, `BIT_WIDTH=8`.
- All weights `01`, all inputs 1, `out_ready=1`:
  - 8 beats produce words 16 (0x10) for idx 0..7;
  - `out_last` is high only at idx 7;
  - first `out_valid` appears 2 cycles after the final beat edge.
- Output 0 weights `11`, inputs 100:
  - `sat_en=1` gives `out_data=0x80` (-128);
  - `sat_en=0` gives 0xC0 (-1600 wrapped);
  - outputs 1..7 (weights `00`) give 0.
- Backpressure:
  - hold `out_ready=0` for 5 cycles at idx 2: data and idx stay stable;
  - a second vector fully accumulates meanwhile, then `in_ready=0` until the drain ends;
  - the second result starts one cycle after `out_last`.
- `clear` after 3 beats, then 8 fresh beats of input 1 with weights `01`: every output is 16, with no residue from the aborted beats.
- `rst` asserted one cycle at idx 3 mid-drain:
  - next cycle `out_valid=0`;
  - `in_ready=1` after release;
  - the next vector drains from idx 0.
- Weights mixing `10` and `11` on the two lanes with inputs (5, 7): the term per beat is -12, and 8 beats give -96 (0xA0) in both modes.

Source files
------------

// File: rtl/ternary_pkg.sv
// Shared definitions for the streaming ternary matrix-vector multiplier:
// weight encodings, FSM state types and the output clamp/wrap helper.
package ternary_pkg;

  localparam logic [1:0] W_ZERO    = 2'b00;
  localparam logic [1:0] W_POS     = 2'b01;
  localparam int         W_NEG_BIT = 1;

  typedef enum logic {ACCUM, FULL}  acc_state_e;
  typedef enum logic {EMPTY, DRAIN} bank_state_e;

  // Returns acc clamped to a bw-bit signed range when sat_en is set,
  // otherwise acc unchanged; the caller keeps the low bw bits.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] acc,
                                                   input logic sat_en,
                                                   input int bw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bw - 1));
    if (!sat_en)  return acc;
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/ternary_mvm_stream_lane_term.sv
// Combinational per-output term: sum over lanes of +x, -x or 0 selected by
// each lane's 2-bit ternary weight.
module ternary_lane_term
  import ternary_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int BIT_WIDTH = 8,
  parameter int ACC_W     = 13
) (
  input  logic [LANES*BIT_WIDTH-1:0] data,
  input  logic [2*LANES-1:0]         w,
  output logic signed [ACC_W-1:0]    term
);

  always_comb begin
    // NOTE: term gets a value before the loop so no path leaves it unassigned
    // (no latch), and blocking '=' lets each lane see the running sum.
    term = '0;
    for (int k = 0; k < LANES; k++) begin
      if (w[2*k+W_NEG_BIT])
        term = term - ACC_W'(signed'(data[k*BIT_WIDTH +: BIT_WIDTH]));
      else if (w[2*k +: 2] == W_POS)
        term = term + ACC_W'(signed'(data[k*BIT_WIDTH +: BIT_WIDTH]));
    end
  end

endmodule

// File: rtl/ternary_mvm_stream.sv
// Streaming ternary matrix-vector multiplier: accumulates OUT_LEN dot products
// over IN_LEN/LANES beats, then drains them through a double-buffered bank.
module ternary_mvm_stream
  import ternary_pkg::*;
#(
  parameter int IN_LEN    = 16,
  parameter int OUT_LEN   = 8,
  parameter int BIT_WIDTH = 8,
  parameter int LANES     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          sat_en,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*BIT_WIDTH-1:0]    in_data,
  input  logic [2*LANES*OUT_LEN-1:0]    in_w,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BIT_WIDTH-1:0]          out_data,
  output logic [$clog2(OUT_LEN)-1:0]    out_idx,
  output logic                          out_last
);

  localparam int BEATS = IN_LEN / LANES;
  localparam int ACC_W = BIT_WIDTH + $clog2(IN_LEN) + 1;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W = $clog2(OUT_LEN);

  acc_state_e              acc_state;
  bank_state_e             bank_state;
  logic [CNT_W-1:0]        beat_cnt;
  logic signed [ACC_W-1:0] acc       [OUT_LEN];
  logic signed [ACC_W-1:0] term      [OUT_LEN];
  logic [BIT_WIDTH-1:0]    bank      [OUT_LEN];
  logic [BIT_WIDTH-1:0]    bank_next [OUT_LEN];
  logic                    beat_fire;
  logic                    transfer;
  logic                    out_fire;

  // Weights arrive lane-major; regroup them so each term unit sees its column.
  for (genvar j = 0; j < OUT_LEN; j++) begin : g_out
    logic [2*LANES-1:0] w_col;
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign w_col[2*k +: 2] = in_w[2*(k*OUT_LEN+j) +: 2];
    end
    ternary_lane_term #(
      .LANES     (LANES),
      .BIT_WIDTH (BIT_WIDTH),
      .ACC_W     (ACC_W)
    ) u_term (
      .data (in_data),
      .w    (w_col),
      .term (term[j])
    );
  end

  assign in_ready  = (acc_state == ACCUM) && !rst;
  assign beat_fire = in_valid && in_ready && !clear;
  assign transfer  = (acc_state == FULL) && (bank_state == EMPTY) && !clear;
  assign out_valid = (bank_state == DRAIN);
  assign out_fire  = out_valid && out_ready;
  assign out_last  = out_valid && (out_idx == IDX_W'(OUT_LEN - 1));
  assign out_data  = out_valid ? bank[out_idx] : '0;

  always_comb begin
    for (int j = 0; j < OUT_LEN; j++)
      bank_next[j] = BIT_WIDTH'(sat_trunc(64'(acc[j]), sat_en, BIT_WIDTH));
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_state <= ACCUM;
      beat_cnt  <= '0;
      for (int j = 0; j < OUT_LEN; j++) acc[j] <= '0;
    end else if (clear) begin
      acc_state <= ACCUM;
      beat_cnt  <= '0;
    end else if (beat_fire) begin
      for (int j = 0; j < OUT_LEN; j++)
        acc[j] <= (beat_cnt == '0) ? term[j] : acc[j] + term[j];
      if (beat_cnt == CNT_W'(BEATS - 1)) begin
        beat_cnt  <= '0;
        acc_state <= FULL;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end else if (transfer) begin
      acc_state <= ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_state <= EMPTY;
      out_idx    <= '0;
    end else if (transfer) begin
      bank_state <= DRAIN;
      out_idx    <= '0;
    end else if (out_fire) begin
      if (out_last) begin
        bank_state <= EMPTY;
        out_idx    <= '0;
      end else begin
        out_idx <= out_idx + 1'b1;
      end
    end
  end

  // NOTE: the bank is storage only; out_data is masked while EMPTY, so it
  // needs no reset.
  always_ff @(posedge clk) begin
    if (!rst && transfer)
      for (int j = 0; j < OUT_LEN; j++) bank[j] <= bank_next[j];
  end

endmodule

// File: tb/tb_ternary_mvm_stream.sv
// Directed bench for ternary_mvm_stream: a vector table plus hand-written
// backpressure, clear and mid-drain reset sequences.
module tb_ternary_mvm_stream;

  logic        clk = 1'b0;
  logic        rst, clear, sat_en, in_valid, out_ready;
  logic        in_ready, out_valid, out_last;
  logic [15:0] in_data;
  logic [31:0] in_w;
  logic [7:0]  out_data;
  logic [2:0]  out_idx;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] a, b;
    logic [1:0] w0a, w0b, wra, wrb;
    logic       sat;
    logic [7:0] e0, er;
  } vec_t;

  vec_t vecs [8];

  ternary_mvm_stream #(.IN_LEN(16), .OUT_LEN(8), .BIT_WIDTH(8), .LANES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .sat_en    (sat_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_w      (in_w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_w(input logic [1:0] w0a, w0b, wra, wrb);
    logic [31:0] w;
    logic [1:0]  c;
    w = '0;
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 8; j++) begin
        if (j == 0) c = (k == 0) ? w0a : w0b;
        else        c = (k == 0) ? wra : wrb;
        w[2*(k*8+j) +: 2] = c;
      end
    return w;
  endfunction

  task automatic send_beats(input logic [7:0] a, b, input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      in_data  = {b, a};
      in_w     = w;
      in_valid = 1'b1;
      while (!in_ready && t < 100) begin
        step();
        t++;
      end
      check("in_ready wait", in_ready, 1);
      step();
    end
    in_valid = 1'b0;
  endtask

  // Called right after the final beat edge with the bank empty.
  task automatic check_latency(input string tag);
    check({tag, " full in_ready"}, in_ready, 0);
    check({tag, " pre valid"}, out_valid, 0);
    step();
    check({tag, " first valid"}, out_valid, 1);
    check({tag, " first idx"}, out_idx, 0);
    check({tag, " in_ready back"}, in_ready, 1);
  endtask

  task automatic drain_check(input logic [7:0] e0, er, input string tag);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      int t;
      t = 0;
      while (!out_valid && t < 50) begin
        step();
        t++;
      end
      check($sformatf("%s valid %0d", tag, i), out_valid, 1);
      check($sformatf("%s idx %0d", tag, i), out_idx, i);
      check($sformatf("%s data %0d", tag, i), out_data, (i == 0) ? e0 : er);
      check($sformatf("%s last %0d", tag, i), out_last, (i == 7) ? 1 : 0);
      step();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{a: 8'd1,   b: 8'd1,   w0a: 2'b01, w0b: 2'b01, wra: 2'b01, wrb: 2'b01, sat: 1'b1, e0: 8'h10, er: 8'h10};
    vecs[1] = '{a: 8'd100, b: 8'd100, w0a: 2'b11, w0b: 2'b11, wra: 2'b00, wrb: 2'b00, sat: 1'b1, e0: 8'h80, er: 8'h00};
    vecs[2] = '{a: 8'd100, b: 8'd100, w0a: 2'b11, w0b: 2'b11, wra: 2'b00, wrb: 2'b00, sat: 1'b0, e0: 8'hC0, er: 8'h00};
    vecs[3] = '{a: 8'd5,   b: 8'd7,   w0a: 2'b10, w0b: 2'b11, wra: 2'b10, wrb: 2'b11, sat: 1'b1, e0: 8'hA0, er: 8'hA0};
    vecs[4] = '{a: 8'd5,   b: 8'd7,   w0a: 2'b10, w0b: 2'b11, wra: 2'b10, wrb: 2'b11, sat: 1'b0, e0: 8'hA0, er: 8'hA0};
    vecs[5] = '{a: 8'd127, b: 8'd127, w0a: 2'b01, w0b: 2'b01, wra: 2'b01, wrb: 2'b10, sat: 1'b1, e0: 8'h7F, er: 8'h00};
    vecs[6] = '{a: 8'd127, b: 8'd127, w0a: 2'b01, w0b: 2'b01, wra: 2'b01, wrb: 2'b10, sat: 1'b0, e0: 8'hF0, er: 8'h00};
    vecs[7] = '{a: 8'hFD,  b: 8'd4,   w0a: 2'b01, w0b: 2'b11, wra: 2'b11, wrb: 2'b01, sat: 1'b1, e0: 8'hC8, er: 8'h38};

    rst = 1'b1; clear = 1'b0; sat_en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_w = '0;
    step();
    step();
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset in_ready", in_ready, 0);
    rst = 1'b0;
    step();
    check("release in_ready", in_ready, 1);
    check("release out_idx", out_idx, 0);
    check("release out_last", out_last, 0);

    for (int v = 0; v < 8; v++) begin
      sat_en = vecs[v].sat;
      send_beats(vecs[v].a, vecs[v].b, mk_w(vecs[v].w0a, vecs[v].w0b, vecs[v].wra, vecs[v].wrb), 8);
      check_latency($sformatf("v%0d", v));
      drain_check(vecs[v].e0, vecs[v].er, $sformatf("v%0d", v));
    end

    // Backpressure: second vector accumulates while the first is held at idx 2.
    sat_en = 1'b1;
    send_beats(8'd1, 8'd1, mk_w(2'b01, 2'b01, 2'b01, 2'b01), 8);
    check_latency("bp");
    fork
      send_beats(8'd3, 8'd3, mk_w(2'b01, 2'b01, 2'b11, 2'b11), 8);
      begin
        int t;
        t = 0;
        out_ready = 1'b1;
        while (out_idx != 3'd2 && t < 50) begin
          step();
          t++;
        end
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          step();
          check("bp hold idx", out_idx, 2);
          check("bp hold data", out_data, 8'h10);
          check("bp hold valid", out_valid, 1);
        end
        out_ready = 1'b1;
        for (int i = 2; i < 8; i++) begin
          check($sformatf("bp idx %0d", i), out_idx, i);
          check($sformatf("bp data %0d", i), out_data, 8'h10);
          check($sformatf("bp last %0d", i), out_last, (i == 7) ? 1 : 0);
          if (i == 7) check("bp in_ready blocked", in_ready, 0);
          step();
        end
        out_ready = 1'b0;
      end
    join
    check("bp bubble valid", out_valid, 0);
    check("bp bubble in_ready", in_ready, 0);
    step();
    check("bp second valid", out_valid, 1);
    check("bp second idx", out_idx, 0);
    check("bp second in_ready", in_ready, 1);
    drain_check(8'h30, 8'hD0, "bp2");

    // Clear after 3 beats, with a beat presented in the clear cycle.
    send_beats(8'd50, 8'd50, mk_w(2'b01, 2'b01, 2'b01, 2'b01), 3);
    clear = 1'b1; in_valid = 1'b1; in_data = {8'd100, 8'd100};
    step();
    clear = 1'b0; in_valid = 1'b0;
    check("clear in_ready", in_ready, 1);
    check("clear out_valid", out_valid, 0);
    send_beats(8'd1, 8'd1, mk_w(2'b01, 2'b01, 2'b01, 2'b01), 8);
    check_latency("clr");
    drain_check(8'h10, 8'h10, "clr");

    // Reset mid-drain at idx 3.
    send_beats(8'd1, 8'd1, mk_w(2'b01, 2'b01, 2'b01, 2'b01), 8);
    step();
    begin
      int t;
      t = 0;
      out_ready = 1'b1;
      while (out_idx != 3'd3 && t < 50) begin
        step();
        t++;
      end
      check("rst reach idx3", out_idx, 3);
    end
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    check("rst out_valid", out_valid, 0);
    check("rst out_last", out_last, 0);
    check("rst out_data", out_data, 0);
    check("rst in_ready held", in_ready, 0);
    rst = 1'b0;
    step();
    check("rst in_ready release", in_ready, 1);
    check("rst still empty", out_valid, 0);
    send_beats(8'd2, 8'd3, mk_w(2'b01, 2'b01, 2'b00, 2'b00), 8);
    check_latency("rst");
    drain_check(8'h28, 8'h00, "rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
